key_command_issuer: RTL
=======================

// Module: key_command_issuer
// PURPOSE
//   Front end that drives the 16-bit counter/shifter FSM's command interface from board controls.
//   Debounces the raw active-low push button KEY[0] and issues exactly one single-cycle enable
//   pulse per physical press. Captures the switch settings (check, mode, direction, value) on the
//   pulse cycle, so the downstream FSM always sees a stable, coherent command alongside enable.
// PARAMETERS
//   DB_CYCLES  1000000  consecutive stable cycles required to accept a level change (20 ms @ 50 MHz); minimum 2
//   DB_W       20       debounce counter width; must satisfy 2**DB_W >= DB_CYCLES
// PORTS
//   clock         in   1   system clock, 50 MHz
//   reset         in   1   synchronous, active-high reset
//   key_n         in   1   raw push button, active-low, asynchronous, bouncy
//   sw_check      in   1   raw switch: check/hold command bit
//   sw_mode       in   1   raw switch: 0 = shift, 1 = add/sub
//   sw_direction  in   1   raw switch: 0 = left/up, 1 = right/down
//   sw_value      in   4   raw switches: step value
//   enable        out  1   one-cycle command strobe to the FSM
//   check         out  1   latched check bit, valid from the enable cycle onward
//   mode          out  1   latched mode bit
//   direction     out  1   latched direction bit
//   value         out  4   latched step value
//   busy          out  1   high whenever state != IDLE
//   press_count   out  8   number of enable pulses issued; wraps modulo 256
// BEHAVIOUR
//   - Synchronisation: key_n and all sw_* inputs pass through 2-FF synchronisers.
//     key synchroniser flops reset to 1 (released). sw synchroniser flops reset to 0.
//   - Reset (synchronous, priority over everything): state=IDLE; debounce counter=0; enable=0;
//     check=mode=direction=0; value=0; busy=0; press_count=0.
//   - FSM states; "key" means the synchronised key_n.
//     IDLE: key==0 -> PRESS_WAIT, counter=0.
//     PRESS_WAIT: key==1 -> IDLE (bounce rejected, no pulse). Otherwise counter++.
//       When counter==DB_CYCLES-1 with key==0 -> PRESSED; the same edge registers enable=1.
//     PRESSED: key==0 -> stay. key==1 -> RELEASE_WAIT, counter=0.
//     RELEASE_WAIT: key==0 -> PRESSED, counter=0, NO new pulse. Otherwise counter++.
//       When counter==DB_CYCLES-1 -> IDLE.
//   - Latency: key_n falls and stays low before edge k. enable is high in exactly the cycle
//     following edge k+2+DB_CYCLES. enable is high for exactly 1 cycle, never 2 consecutive.
//   - Command capture: check/mode/direction/value load the synchronised sw_* values on the same
//     edge that sets enable=1, and hold otherwise. Switch changes between presses are invisible
//     until the next pulse.
//   - press_count increments on the edge that sets enable=1; 8'hFF wraps to 8'h00.
//   - Key held low through reset: after reset deasserts this is treated as a new press and
//     yields one pulse DB_CYCLES+2 cycles later.
//   - Reset during PRESS_WAIT suppresses the pending pulse.
//   - Counter saturation: the counter never exceeds DB_CYCLES-1. Any state change clears it.
// TESTING  (DB_CYCLES=4, DB_W=3, 20 ns clock)
//   1 Clean press: sw={chk=1,mode=0,dir=0,val=0}, key_n low for 20 cycles -> one enable
//     6 cycles after the fall, check=1, mode=0, press_count=1, busy high until release + 6 cycles.
//   2 Press bounce: key_n low 2, high 1, low 2, high 1, then low 15 -> exactly one enable,
//     6 cycles after the final fall, press_count=1.
//   3 Release bounce: in PRESSED, key_n high 2, low 1, high 15 -> no second enable,
//     busy drops 6 cycles after the last rise.
//   4 Five presses with mode=1, dir=0, val=4'b0110; change val to 4'b0011 between presses 3 and 4
//     -> 5 pulses; value=6 for pulses 1-3 and 3 for pulses 4-5; press_count=5.
//   5 Reset asserted 2 cycles into PRESS_WAIT with key_n held low -> no pulse while in reset,
//     all outputs 0; after release, one enable 6 cycles later.
//   6 256 clean presses -> press_count reads 8'h00 after the last; enable never high on 2 adjacent cycles.

Source files
------------

// File: rtl/key_command_issuer.sv
`default_nettype none
// ============================================================================
// Module   : key_command_issuer
// Brief    : Debounces KEY[0] into one enable strobe per press and latches the
//            switch command alongside it for the counter/shifter FSM.
// Revision : 1.0 - initial release
// ============================================================================
module key_command_issuer #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_n,
    input  logic       sw_check,
    input  logic       sw_mode,
    input  logic       sw_direction,
    input  logic [3:0] sw_value,
    output logic       enable,
    output logic       check,
    output logic       mode,
    output logic       direction,
    output logic [3:0] value,
    output logic       busy,
    output logic [7:0] press_count
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic            key_meta_q;
    logic            key_sync_q;
    logic [6:0]      sw_meta_q;
    logic [6:0]      sw_sync_q;

    state_t          state_q;
    logic [DB_W-1:0] cnt_q;
    logic            enable_q;
    logic            check_q;
    logic            mode_q;
    logic            direction_q;
    logic [3:0]      value_q;
    logic            busy_q;
    logic [7:0]      press_count_q;

    // Key synchroniser idles at 1 (released) so reset never fakes a press edge
    always_ff @(posedge clock) begin
        if (reset) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            sw_meta_q  <= 7'd0;
            sw_sync_q  <= 7'd0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= {sw_check, sw_mode, sw_direction, sw_value};
            sw_sync_q  <= sw_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            enable_q      <= 1'b0;
            check_q       <= 1'b0;
            mode_q        <= 1'b0;
            direction_q   <= 1'b0;
            value_q       <= 4'd0;
            busy_q        <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!key_sync_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (key_sync_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Accepted press: strobe and capture the command together
                        state_q       <= PRESSED;
                        cnt_q         <= '0;
                        enable_q      <= 1'b1;
                        check_q       <= sw_sync_q[6];
                        mode_q        <= sw_sync_q[5];
                        direction_q   <= sw_sync_q[4];
                        value_q       <= sw_sync_q[3:0];
                        press_count_q <= press_count_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (key_sync_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_sync_q) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign enable      = enable_q;
    assign check       = check_q;
    assign mode        = mode_q;
    assign direction   = direction_q;
    assign value       = value_q;
    assign busy        = busy_q;
    assign press_count = press_count_q;

endmodule
`default_nettype wire
